// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode encodings and
// the default almost-full threshold.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Two words of margin below full; never below 1 so tiny FIFOs stay legal.
  function automatic int default_afull(input int logd);
    int d;
    d = 1 << logd;
    return (d > 2) ? d - 2 : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Handshake and status bundle between a FIFO producer/consumer (master)
// and the FIFO controller (slave).
interface sync_fifo_ctl_if #(
  parameter int W    = 8,
  parameter int LOGD = 7
) ();

  logic          i_wr;
  logic [W-1:0]  i_data;
  logic          i_rd;
  logic          i_clr_err;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          o_full;
  logic          o_empty;
  logic          o_afull;
  logic          o_aempty;
  logic [LOGD:0] o_fill;
  logic          o_overflow;
  logic          o_underflow;

  modport master (
    output i_wr, i_data, i_rd, i_clr_err,
    input  o_data, o_valid, o_full, o_empty, o_afull, o_aempty,
           o_fill, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr, i_data, i_rd, i_clr_err,
    output o_data, o_valid, o_full, o_empty, o_afull, o_aempty,
           o_fill, o_overflow, o_underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one synchronous write port and a read port that is
// either registered (reset to zero) or asynchronous.
module fifo_ram #(
  parameter int W        = 8,
  parameter int LOGD     = 7,
  parameter int ASYNC_RD = 0
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            wr_en,
  input  logic [LOGD-1:0] wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_en,
  input  logic [LOGD-1:0] rd_addr,
  output logic [W-1:0]    rd_data
);

  logic [W-1:0] mem [2**LOGD];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (ASYNC_RD != 0) begin : g_async_rd
      logic unused_rd_ctl;
      assign unused_rd_ctl = ^{i_reset, rd_en};
      assign rd_data       = mem[rd_addr];
    end else begin : g_reg_rd
      // Read-before-write: a same-address write this edge is not seen.
      always_ff @(posedge clk) begin
        if (i_reset)    rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_ctl.sv
// Synchronous single-clock FIFO controller: full-depth pointers with wrap
// bit, occupancy/threshold flags, sticky error flags, REG or FWFT read mode.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int W      = 8,
  parameter int LOGD   = 7,
  parameter int FWFT   = FIFO_MODE_REG,
  parameter int AFULL  = default_afull(LOGD),
  parameter int AEMPTY = 1
) (
  input logic           clk,
  input logic           i_reset,
  sync_fifo_ctl_if.slave bus
);

  localparam int D = 2**LOGD;
  localparam logic [LOGD:0] PTR_ONE  = (LOGD+1)'(1);
  localparam logic [LOGD:0] AFULL_T  = (LOGD+1)'(AFULL);
  localparam logic [LOGD:0] AEMPTY_T = (LOGD+1)'(AEMPTY);

  generate
    if (LOGD < 1) begin : g_bad_logd
      $error("sync_fifo_ctl: LOGD must be at least 1");
    end
    if (AFULL < 1 || AFULL > D) begin : g_bad_afull
      $error("sync_fifo_ctl: AFULL out of range 1..D");
    end
    if (AEMPTY < 0 || AEMPTY > D-1) begin : g_bad_aempty
      $error("sync_fifo_ctl: AEMPTY out of range 0..D-1");
    end
    if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_ctl: FWFT must be 0 or 1");
    end
  endgenerate

  logic [LOGD:0] wr_ptr, rd_ptr, fill;
  logic          full, empty, rd_ok, wr_ok;
  logic          overflow, underflow;
  logic [W-1:0]  ram_rd_data;

  assign fill  = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOGD-1:0] == rd_ptr[LOGD-1:0]) &&
                 (wr_ptr[LOGD] != rd_ptr[LOGD]);

  // No bypass: an empty FIFO refuses the read even when a write arrives.
  assign rd_ok = bus.i_rd && !empty;
  assign wr_ok = bus.i_wr && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.i_wr && !wr_ok)  overflow <= 1'b1;
      else if (bus.i_clr_err)  overflow <= 1'b0;
      if (bus.i_rd && !rd_ok)  underflow <= 1'b1;
      else if (bus.i_clr_err)  underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .W        (W),
    .LOGD     (LOGD),
    .ASYNC_RD (FWFT)
  ) u_ram (
    .clk     (clk),
    .i_reset (i_reset),
    .wr_en   (wr_ok && !i_reset),
    .wr_addr (wr_ptr[LOGD-1:0]),
    .wr_data (bus.i_data),
    .rd_en   (rd_ok && !i_reset),
    .rd_addr (rd_ptr[LOGD-1:0]),
    .rd_data (ram_rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.o_valid = !empty;
    end else begin : g_reg
      logic rd_vld_p1;
      // ---- stage p1: registered read data and its valid pulse ----
      always_ff @(posedge clk) begin
        if (i_reset) rd_vld_p1 <= 1'b0;
        else         rd_vld_p1 <= rd_ok;
      end
      assign bus.o_valid = rd_vld_p1;
    end
  endgenerate

  assign bus.o_data      = ram_rd_data;
  assign bus.o_fill      = fill;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_afull     = (fill >= AFULL_T);
  assign bus.o_aempty    = (fill <= AEMPTY_T);
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench: one registered-output and one FWFT FIFO (D=4, AFULL=3,
// AEMPTY=1) driven with identical stimulus, checked against hand values.
module tb_sync_fifo_ctl;

  logic clk = 1'b0;
  logic i_reset;
  always #5 clk = ~clk;

  sync_fifo_ctl_if #(.W(8), .LOGD(2)) f0 ();
  sync_fifo_ctl_if #(.W(8), .LOGD(2)) f1 ();

  sync_fifo_ctl #(.W(8), .LOGD(2), .FWFT(0), .AFULL(3), .AEMPTY(1)) dut0 (
    .clk(clk), .i_reset(i_reset), .bus(f0));
  sync_fifo_ctl #(.W(8), .LOGD(2), .FWFT(1), .AFULL(3), .AEMPTY(1)) dut1 (
    .clk(clk), .i_reset(i_reset), .bus(f1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    f0.i_wr = wr; f0.i_data = d; f0.i_rd = rd; f0.i_clr_err = clr;
    f1.i_wr = wr; f1.i_data = d; f1.i_rd = rd; f1.i_clr_err = clr;
  endtask

  // Expected flags follow from the fill level alone for D=4, AFULL=3, AEMPTY=1.
  task automatic status(input string tag, input int fill);
    chk({tag, ".fill0"},   32'(f0.o_fill),   32'(fill));
    chk({tag, ".fill1"},   32'(f1.o_fill),   32'(fill));
    chk({tag, ".empty0"},  32'(f0.o_empty),  32'(fill == 0));
    chk({tag, ".empty1"},  32'(f1.o_empty),  32'(fill == 0));
    chk({tag, ".full0"},   32'(f0.o_full),   32'(fill == 4));
    chk({tag, ".full1"},   32'(f1.o_full),   32'(fill == 4));
    chk({tag, ".afull0"},  32'(f0.o_afull),  32'(fill >= 3));
    chk({tag, ".afull1"},  32'(f1.o_afull),  32'(fill >= 3));
    chk({tag, ".aempty0"}, 32'(f0.o_aempty), 32'(fill <= 1));
    chk({tag, ".aempty1"}, 32'(f1.o_aempty), 32'(fill <= 1));
    chk({tag, ".valid1"},  32'(f1.o_valid),  32'(fill != 0));
  endtask

  task automatic errs(input string tag, input logic ovf, input logic unf);
    chk({tag, ".ovf0"}, 32'(f0.o_overflow),  32'(ovf));
    chk({tag, ".ovf1"}, 32'(f1.o_overflow),  32'(ovf));
    chk({tag, ".unf0"}, 32'(f0.o_underflow), 32'(unf));
    chk({tag, ".unf1"}, 32'(f1.o_underflow), 32'(unf));
  endtask

  // Pop one word while checking it in both modes: FWFT before the edge, REG after.
  task automatic pop_chk(input string tag, input logic [7:0] exp, input logic wr, input logic [7:0] d);
    drive(wr, d, 1'b1, 1'b0);
    chk({tag, ".data1"}, 32'(f1.o_data), 32'(exp));
    tick();
    chk({tag, ".data0"},  32'(f0.o_data),  32'(exp));
    chk({tag, ".valid0"}, 32'(f0.o_valid), 32'd1);
  endtask

  logic [7:0] seq [4];
  logic [7:0] q [$];

  initial begin
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    status("rst", 0);
    errs("rst", 1'b0, 1'b0);
    chk("rst.valid0", 32'(f0.o_valid), 32'd0);
    chk("rst.data0",  32'(f0.o_data),  32'h00);

    // Fill to full, then a refused fifth write
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, seq[k], 1'b0, 1'b0);
      tick();
      status($sformatf("fill%0d", k + 1), k + 1);
    end
    chk("fill.head1", 32'(f1.o_data), 32'h11);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    status("ovf", 4);
    errs("ovf", 1'b1, 1'b0);

    // Drain in order, then one refused read
    for (int k = 0; k < 4; k++) begin
      pop_chk($sformatf("drain%0d", k), seq[k], 1'b0, 8'h00);
      status($sformatf("drain%0d", k), 3 - k);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    status("unf", 0);
    errs("unf", 1'b1, 1'b1);
    chk("unf.valid0", 32'(f0.o_valid), 32'd0);
    chk("unf.data0",  32'(f0.o_data),  32'h44);

    // Error clear, then clear racing a refused read
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    errs("clr", 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    errs("clr_race", 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    errs("clr2", 1'b0, 1'b0);

    // Simultaneous write+read on a full FIFO
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(k + 1), 1'b0, 1'b0);
      tick();
    end
    status("refill", 4);
    pop_chk("full_wr_rd", 8'h01, 1'b1, 8'hAA);
    status("full_wr_rd", 4);
    errs("full_wr_rd", 1'b0, 1'b0);
    q = '{8'h02, 8'h03, 8'h04, 8'hAA};
    for (int k = 0; k < 4; k++) pop_chk($sformatf("full_drain%0d", k), q[k], 1'b0, 8'h00);
    status("full_drain", 0);

    // Simultaneous write+read on an empty FIFO: read refused
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    tick();
    status("empty_wr_rd", 1);
    errs("empty_wr_rd", 1'b0, 1'b1);
    chk("empty_wr_rd.valid0", 32'(f0.o_valid), 32'd0);
    chk("empty_wr_rd.data1",  32'(f1.o_data),  32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("empty_pop.data0", 32'(f0.o_data), 32'h77);
    errs("empty_pop", 1'b0, 1'b0);
    status("empty_pop", 0);

    // Wrap-around at fill level 2
    drive(1'b1, 8'hF0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hF1, 1'b0, 1'b0); tick();
    q = '{8'hF0, 8'hF1};
    for (int i = 0; i < 10; i++) begin
      pop_chk($sformatf("wrap%0d", i), q[0], 1'b1, 8'(i));
      void'(q.pop_front());
      q.push_back(8'(i));
      chk($sformatf("wrap%0d.fill0", i), 32'(f0.o_fill), 32'd2);
    end
    pop_chk("wrap_tail0", 8'h08, 1'b0, 8'h00);
    pop_chk("wrap_tail1", 8'h09, 1'b0, 8'h00);
    status("wrap_end", 0);

    // Reset mid-operation with a write presented
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h31 + 8'(k), 1'b0, 1'b0);
      tick();
    end
    status("pre_rst", 3);
    drive(1'b1, 8'h34, 1'b0, 1'b0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    status("mid_rst", 0);
    errs("mid_rst", 1'b0, 1'b0);
    chk("mid_rst.valid0", 32'(f0.o_valid), 32'd0);
    chk("mid_rst.data0",  32'(f0.o_data),  32'h00);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    status("post_rst_wr", 1);
    pop_chk("post_rst_rd", 8'h5A, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    status("final", 0);
    chk("final.valid0", 32'(f0.o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised synchronous single-clock FIFO. It stores `2**LOGD` words of `W` bits and makes the full depth usable. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and two read modes: registered-output or first-word-fall-through. It is the drop-in buffer between the UART/bus front ends and downstream consumers that need flow-control margin.

## Interface
Parameters:
- `W`, default 8: data width in bits.
- `LOGD`, default 7: log2 of depth; depth `D = 2**LOGD`; `LOGD >= 1`.
- `FWFT`, default 0: read mode. 0 = registered output. 1 = first-word-fall-through.
- `AFULL`, default `D-2`: `o_afull` asserts when `o_fill >= AFULL`. Legal range 1..D.
- `AEMPTY`, default 1: `o_aempty` asserts when `o_fill <= AEMPTY`. Legal range 0..D-1.

Ports:
- `clk`  in  1  clock; all logic acts on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_wr`  in  1  write request.
- `i_data`  in  W  write data.
- `i_rd`  in  1  read request (pop).
- `i_clr_err`  in  1  clears the sticky error flags.
- `o_data`  out  W  read data.
- `o_valid`  out  1  in mode 0: `o_data` holds a freshly popped word. In mode 1: equals `!o_empty`.
- `o_full`  out  1  `o_fill == D`.
- `o_empty`  out  1  `o_fill == 0`.
- `o_afull`  out  1  `o_fill >= AFULL`.
- `o_aempty`  out  1  `o_fill <= AEMPTY`.
- `o_fill`  out  LOGD+1  stored word count, 0..D.
- `o_overflow`  out  1  sticky: a write was refused.
- `o_underflow`  out  1  sticky: a read was refused.

## Operation
Pointers and count:
- `wr_ptr` and `rd_ptr` are LOGD+1 bits wide. The low LOGD bits address memory; the MSB is a wrap bit.
- Full: addresses equal and MSBs differ. Empty: pointers fully equal.
- `o_fill = wr_ptr - rd_ptr`, modulo `2**(LOGD+1)`.

Acceptance rules:
- Read accepted (`rd_ok`) = `i_rd && !o_empty`.
- Write accepted (`wr_ok`) = `i_wr && (!o_full || rd_ok)`. A write into a full FIFO succeeds only with a simultaneous accepted read.
- Write into an empty FIFO with a simultaneous read: the write is accepted and the read is refused. There is no bypass.
- Pointers increment by 1 on acceptance and wrap naturally.

Read modes:
- Mode 0: on `rd_ok`, `o_data <= mem[rd_addr]` and `o_valid <= 1`; otherwise `o_valid <= 0` and `o_data` holds its value.
- Mode 1: `o_data = mem[rd_addr]` combinationally. `rd_ok` advances to the next word.

Errors:
- `o_overflow` sets on `i_wr && !wr_ok`.
- `o_underflow` sets on `i_rd && !rd_ok`.
- `i_clr_err` clears both flags. A new error in the same cycle wins, so the flag stays set.

Reset:
- Clears both pointers, `o_valid`, `o_data` (mode 0 only) and both error flags. Memory is not cleared.
- Reset mid-operation discards all contents. Writes and reads presented in the reset cycle are ignored.

## Timing
- Reset values: `o_fill=0`, `o_empty=1`, `o_full=0`, `o_afull=0` (since AFULL≥1), `o_aempty=1`, `o_valid=0`, `o_overflow=0`, `o_underflow=0`, `o_data=0` in mode 0.
- All status outputs are combinational from registered pointers. They reflect an accepted write or read in the cycle after its edge.
- Mode 0 read latency: 1 cycle from the `rd_ok` edge to `o_data`/`o_valid`. `o_valid` is a single-cycle pulse per accepted read.
- Mode 1 read latency: 0 cycles. A written word appears on `o_data` the cycle after its write edge.
- Write-to-read ordering: a word written at edge N can be read at edge N+1 at the earliest.
- Throughput: one write and one read per cycle, sustained, at any fill level 1..D-1.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_MODE_REG = 0` and `FIFO_MODE_FWFT = 1`;
  - a function computing the default `AFULL` from `LOGD`.
- Sub-module `fifo_ram`: simple dual-port RAM, `W x 2**LOGD`, one synchronous write port. Its read port is either registered or asynchronous, selected by a parameter driven from `FWFT`.
- Pointer, flag and error logic stay in `sync_fifo_ctl`.
- Elaboration check rejects illegal `AFULL`/`AEMPTY` values.

## Test plan
All scenarios use `W=8`, `LOGD=2` (D=4), `AFULL=3`, `AEMPTY=1`, both modes unless noted.
- **Fill to full:** write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `o_fill` steps 1..4; `o_afull` is first seen high once `o_fill`=3; `o_full=1` once `o_fill`=4; a fifth write of 0x55 → `o_overflow=1`, `o_fill` stays 4.
- **Drain:** drain the full FIFO with `i_rd` held → data 0x11, 0x22, 0x33, 0x44 in order. Mode 0 data arrives one cycle after each read with `o_valid` pulses. Mode 1 data is on `o_data` before each pop. After the last pop `o_empty=1`, and one extra read sets `o_underflow`.
- **Simultaneous access:** full FIFO with simultaneous `i_wr`(0xAA) and `i_rd` → both accepted, `o_fill` stays 4, no overflow, 0xAA emerges fifth. Empty FIFO with simultaneous `i_wr`+`i_rd` → `o_fill`=1, `o_underflow=1`.
- **Wrap-around:** 10 write/read pairs of 0x00..0x09 at fill level 2 → output order is preserved across pointer wrap.
- **Reset mid-operation:** assert `i_reset` at `o_fill`=3 with `i_wr` high → next cycle all outputs at reset values; a subsequent write of 0x5A is the next word read.
- **Error clear:** with both error flags set, pulse `i_clr_err` → both flags clear. Pulse `i_clr_err` together with a refused read → `o_underflow` remains 1.
